// File: rtl/rr_hold_arb.sv
// rr_hold_arb: round-robin arbiter for N requesters with ownership hold.
// The winner keeps its grant until it drops req, or until it has held the
// resource for MAX_HOLD cycles. A forced revoke is flagged by a one-cycle
// timeout pulse. Every ownership ends with a single dead (turnaround) cycle.
module rr_hold_arb #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic [7:0]     hcnt;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_onehot;
    logic [IDW-1:0] ptr_next;
    logic           owner_req;
    logic           hold_expired;

    // Rotating priority search: first set req at index >= ptr, then wrap to the low indices
    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[i] && (i >= int'(ptr))) begin
                win_found     = 1'b1;
                win_id        = IDW'(i);
                win_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[i] && (i < int'(ptr))) begin
                win_found     = 1'b1;
                win_id        = IDW'(i);
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Ownership bookkeeping: pointer advance past the winner, owner still requesting, hold limit reached
    always_comb begin
        ptr_next     = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
        owner_req    = |(req & grant);
        hold_expired = (hcnt == 8'(MAX_HOLD));
        busy         = |grant;
    end

    // Arbitration FSM: grant from IDLE, hold in BUSY until release or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            hcnt     <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == ST_IDLE) begin
                if (win_found) begin
                    grant    <= win_onehot;
                    grant_id <= win_id;
                    ptr      <= ptr_next;
                    hcnt     <= 8'd1;
                    state    <= ST_BUSY;
                end
            end else begin
                if (!owner_req) begin
                    // Normal release wins over a simultaneous hold expiry
                    grant    <= '0;
                    grant_id <= '0;
                    hcnt     <= '0;
                    state    <= ST_IDLE;
                end else if (hold_expired) begin
                    // Forced revoke; ptr already points past the owner
                    grant    <= '0;
                    grant_id <= '0;
                    hcnt     <= '0;
                    timeout  <= 1'b1;
                    state    <= ST_IDLE;
                end else begin
                    hcnt <= hcnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_hold_arb.sv
// Testbench for rr_hold_arb (N=4, MAX_HOLD=8): table of per-cycle vectors
// plus a hand-written asynchronous reset sequence.
module tb_rr_hold_arb;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    rr_hold_arb #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] g;
        logic         to;
    } vec_t;

    typedef struct {
        logic [N-1:0] g;
        logic         to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic r, input logic [N-1:0] rq,
                                input logic [N-1:0] g, input logic to);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.g   = g;
        v.to  = to;
        vecs.push_back(v);
    endfunction

    function automatic logic [IDW-1:0] id_of(input logic [N-1:0] oh);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++)
            if (oh[i]) id = IDW'(i);
        return id;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [N-1:0] g, input logic to);
        chk({tag, ".grant"},    32'(grant),    32'(g));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(id_of(g)));
        chk({tag, ".busy"},     32'(busy),     32'(|g));
        chk({tag, ".timeout"},  32'(timeout),  32'(to));
    endtask

    // Drive one cycle at negedge, record expectation, compare after the posedge
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] g, input logic to, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = ~r;
        req   = rq;
        e.g   = g;
        e.to  = to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk_outputs(tag, e.g, e.to);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;

        // 1. reset and single grant (ptr ends at 2)
        add(1, 4'b0000, 4'b0000, 0);
        add(1, 4'b0010, 4'b0000, 0);
        add(0, 4'b0010, 4'b0010, 0);
        add(0, 4'b0010, 4'b0010, 0);
        add(0, 4'b0010, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 0);
        // ptr=2: 0110 must pick requester 2, not 1
        add(0, 4'b0110, 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 0);

        // 2. rotation from ptr=0, each owner holds 2 cycles then drops 1 cycle
        add(1, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1111, 4'b0010, 0);
        add(0, 4'b1101, 4'b0000, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1111, 4'b0100, 0);
        add(0, 4'b1011, 4'b0000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b1111, 4'b1000, 0);
        add(0, 4'b0111, 4'b0000, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0);

        // 3. timeout with req=0101 held
        add(1, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < MAX_HOLD; k++) add(0, 4'b0101, 4'b0001, 0);
        add(0, 4'b0101, 4'b0000, 1);
        for (int k = 0; k < MAX_HOLD; k++) add(0, 4'b0101, 4'b0100, 0);
        add(0, 4'b0101, 4'b0000, 1);
        add(0, 4'b0101, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 0);

        // 4. release in the cycle where hcnt reaches MAX_HOLD
        add(1, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < MAX_HOLD; k++) add(0, 4'b0001, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0);

        // 5. pointer wrap (ptr=1 here, winner 3 wraps it to 0)
        add(0, 4'b1000, 4'b1000, 0);
        add(0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1001, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 0);

        for (int v = 0; v < vecs.size(); v++)
            step(vecs[v].rst, vecs[v].req, vecs[v].g, vecs[v].to, $sformatf("vec%0d", v));

        // 6. asynchronous reset mid-ownership
        step(1, 4'b0000, 4'b0000, 0, "rst6");
        step(0, 4'b0100, 4'b0100, 0, "own6a");
        step(0, 4'b0100, 4'b0100, 0, "own6b");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_rst", 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk_outputs("in_rst", 4'b0000, 1'b0);
        // ptr must be back at 0: 1100 picks requester 2
        step(0, 4'b1100, 4'b0100, 0, "after_rst");
        step(0, 4'b0000, 4'b0000, 0, "after_rel");

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
